// File: rtl/axi4r_sram_slave.sv
// AXI4 read-only slave in front of a synchronous SRAM with one cycle of read latency.
// One burst at a time; returning beats pass through a 2-entry skid FIFO so rready may stall freely.
module axi4r_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     s_arready,
    input  logic                     s_arvalid,
    input  logic [31:0]              s_araddr,
    input  logic [3:0]               s_arid,
    input  logic [7:0]               s_arlen,
    input  logic [2:0]               s_arsize,
    input  logic [1:0]               s_arburst,
    input  logic                     s_rready,
    output logic                     s_rvalid,
    output logic [1:0]               s_rresp,
    output logic [63:0]              s_rdata,
    output logic                     s_rlast,
    output logic [3:0]               s_rid,
    output logic                     mem_en,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    input  logic [63:0]              mem_rdata
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'd8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        arready_r;
    logic        ar_hs_s;

    logic [31:0] addr_r;
    logic [3:0]  id_r;
    logic [7:0]  len_r;
    logic [2:0]  size_r;
    logic [1:0]  burst_r;
    logic        err_r;
    logic [8:0]  beats_left_r;

    logic [31:0] offset_s;
    logic        in_range_s;
    logic [1:0]  beat_resp_s;
    logic        issue_s;

    logic        s2_v_r;
    logic [1:0]  s2_resp_r;
    logic        s2_last_r;
    logic [63:0] ret_data_s;

    logic [63:0] fifo_data_r [2];
    logic [1:0]  fifo_resp_r [2];
    logic        fifo_last_r [2];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  count_r;
    logic        push_s;
    logic        pop_s;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            2'b00:   next_addr = addr;
            2'b01:   next_addr = addr + step;
            2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
            default: next_addr = addr;
        endcase
    endfunction

    function automatic logic burst_illegal(input logic [7:0] len, input logic [2:0] size,
                                           input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_illegal = (size > 3'd3) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    assign s_arready = arready_r;
    assign ar_hs_s   = s_arvalid && arready_r;

    // State register; arready mirrors "next state is IDLE" so it stays low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            arready_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            arready_r <= (state_next_s == IDLE);
        end
    end

    // Next-state logic: leave BURST once the last beat is taken by the master.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (ar_hs_s) begin
                    state_next_s = BURST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BURST: begin
                if (s_rvalid && s_rready && s_rlast) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BURST;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Burst context: captured at AR handshake, address advanced on every issued beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r       <= 32'd0;
            id_r         <= 4'd0;
            len_r        <= 8'd0;
            size_r       <= 3'd0;
            burst_r      <= 2'd0;
            err_r        <= 1'b0;
            beats_left_r <= 9'd0;
        end else if (ar_hs_s) begin
            addr_r       <= s_araddr;
            id_r         <= s_arid;
            len_r        <= s_arlen;
            size_r       <= s_arsize;
            burst_r      <= s_arburst;
            err_r        <= burst_illegal(s_arlen, s_arsize, s_arburst);
            beats_left_r <= {1'b0, s_arlen} + 9'd1;
        end else if (issue_s) begin
            addr_r       <= next_addr(addr_r, size_r, len_r, burst_r);
            beats_left_r <= beats_left_r - 9'd1;
        end
    end

    // Offset wraps modulo 2^32, so addresses below the base land far out of range.
    assign offset_s   = addr_r - BASE_ADDR;
    assign in_range_s = ({32'd0, offset_s} < MEM_BYTES);
    assign mem_addr   = offset_s[AW+2:3];

    // Beat response and issue gating: never more than two beats held between SRAM and R channel.
    always_comb begin
        beat_resp_s = RESP_OKAY;
        if (err_r) begin
            beat_resp_s = RESP_SLVERR;
        end else if (!in_range_s) begin
            beat_resp_s = RESP_DECERR;
        end else begin
            beat_resp_s = RESP_OKAY;
        end
        issue_s = (state_r == BURST) && (beats_left_r != 9'd0) &&
                  ((count_r + {1'b0, s2_v_r}) < 2'd2);
        mem_en  = issue_s && (beat_resp_s == RESP_OKAY);
    end

    // Return stage: the beat whose SRAM data (if any) is on mem_rdata this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r    <= 1'b0;
            s2_resp_r <= 2'b00;
            s2_last_r <= 1'b0;
        end else begin
            s2_v_r    <= issue_s;
            s2_resp_r <= beat_resp_s;
            s2_last_r <= (beats_left_r == 9'd1);
        end
    end

    assign ret_data_s = (s2_resp_r == RESP_OKAY) ? mem_rdata : 64'd0;
    assign push_s     = s2_v_r && !((count_r == 2'd0) && s_rready);
    assign pop_s      = (count_r != 2'd0) && s_rready;

    // Skid FIFO: captures returning beats the master does not take in their return cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_r[i] <= 64'd0;
                fifo_resp_r[i] <= 2'b00;
                fifo_last_r[i] <= 1'b0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= ret_data_s;
                fifo_resp_r[wr_ptr_r] <= s2_resp_r;
                fifo_last_r[wr_ptr_r] <= s2_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // R channel: FIFO head has priority, otherwise the returning beat bypasses straight out.
    always_comb begin
        s_rvalid = 1'b0;
        s_rdata  = 64'd0;
        s_rresp  = 2'b00;
        s_rlast  = 1'b0;
        s_rid    = 4'd0;
        if (count_r != 2'd0) begin
            s_rvalid = 1'b1;
            s_rdata  = fifo_data_r[rd_ptr_r];
            s_rresp  = fifo_resp_r[rd_ptr_r];
            s_rlast  = fifo_last_r[rd_ptr_r];
            s_rid    = id_r;
        end else if (s2_v_r) begin
            s_rvalid = 1'b1;
            s_rdata  = ret_data_s;
            s_rresp  = s2_resp_r;
            s_rlast  = s2_last_r;
            s_rid    = id_r;
        end else begin
            s_rvalid = 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4r_sram_slave.sv
// Directed and randomized bursts against a per-beat reference built from AXI burst arithmetic.
module tb_axi4r_sram_slave;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 64;
    localparam int          AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_arready;
    logic          s_arvalid = 1'b0;
    logic [31:0]   s_araddr = 32'd0;
    logic [3:0]    s_arid = 4'd0;
    logic [7:0]    s_arlen = 8'd0;
    logic [2:0]    s_arsize = 3'd0;
    logic [1:0]    s_arburst = 2'd0;
    logic          s_rready = 1'b0;
    logic          s_rvalid;
    logic [1:0]    s_rresp;
    logic [63:0]   s_rdata;
    logic          s_rlast;
    logic [3:0]    s_rid;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_rdata = 64'd0;

    int checks = 0;
    int errors = 0;
    int en_total = 0;
    int acc_ok_total = 0;
    logic [63:0] mem [DEPTH];

    axi4r_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arready(s_arready), .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rready(s_rready), .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
        if (mem_en) en_total <= en_total + 1;
        if (s_rvalid && s_rready && s_rresp == 2'b00) acc_ok_total <= acc_ok_total + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a0, input int i, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        longint unsigned step, total, base, a;
        step  = 64'd1 << size;
        total = (longint'(len) + 1) * step;
        a     = longint'(a0);
        if (burst == 2'b00) return a0;
        if (burst == 2'b01) return 32'(a + longint'(i) * step);
        base = (a / total) * total;
        return 32'(base + ((a - base) + longint'(i) * step) % total);
    endfunction

    task automatic run_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int mode,
                             input int reset_at);
        logic [63:0] exp_data [$];
        logic [6:0]  exp_ctl [$];
        int          exp_ok, n, c, idx, first_c, en_base, ok_base, outst;
        bit          illegal, done, held_v;
        logic [63:0] held_data;
        logic [7:0]  held_ctl;
        exp_ok  = 0;
        illegal = (size > 3'd3) || (burst == 2'b11) ||
                  (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] a;
            longint      off;
            logic [1:0]  resp;
            a   = beat_addr(addr, i, size, len, burst);
            off = longint'(a) - longint'(BASE);
            if (illegal) resp = 2'b10;
            else if (off < 0 || off >= DEPTH * 8) resp = 2'b11;
            else resp = 2'b00;
            exp_data.push_back(resp == 2'b00 ? mem[int'(off) / 8] : 64'd0);
            exp_ctl.push_back({resp, (i == int'(len)), id});
            if (resp == 2'b00) exp_ok++;
        end

        @(posedge clk); #1;
        s_arvalid = 1'b1; s_araddr = addr; s_arid = id; s_arlen = len;
        s_arsize = size; s_arburst = burst; s_rready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_arready) begin
            check("ar_timeout", 64'(s_arready), 64'd1);
            s_arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        s_araddr  = 32'hDEAD_BEEF;
        en_base = en_total;
        ok_base = acc_ok_total;
        c = 1; idx = 0; first_c = -1; done = 0; held_v = 0;
        held_data = 64'd0; held_ctl = 8'd0;
        while (!done && c < 300) begin
            if (reset_at >= 0 && idx == reset_at) begin
                rst_n = 1'b0; s_rready = 1'b1;
                #1;
                check("rst_rvalid", 64'(s_rvalid), 64'd0);
                check("rst_arready", 64'(s_arready), 64'd0);
                check("rst_mem_en", 64'(mem_en), 64'd0);
                check("rst_rdata", s_rdata, 64'd0);
                @(negedge clk); rst_n = 1'b1;
                @(negedge clk);
                check("arready_after_rst", 64'(s_arready), 64'd1);
                check("rvalid_after_rst", 64'(s_rvalid), 64'd0);
                return;
            end
            if (mode == 0) s_rready = 1'b1;
            else if (mode == 1) s_rready = (c % 3 == 2);
            else s_rready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (held_v) begin
                check("hold_data", s_rdata, held_data);
                check("hold_ctl", 64'({s_rvalid, s_rresp, s_rlast, s_rid}), 64'(held_ctl));
            end
            check("arready_busy", 64'(s_arready), 64'd0);
            outst = (en_total - en_base) + int'(mem_en) - (acc_ok_total - ok_base);
            check("outstanding_le2", 64'(outst <= 2), 64'd1);
            if (s_rvalid) begin
                if (first_c < 0) begin
                    first_c = c;
                    check("first_rvalid_cycle", 64'(c), 64'd2);
                end
                if (s_rready) begin
                    if (idx > int'(len)) begin
                        check("extra_beat", 64'(idx), 64'(len));
                    end else begin
                        check("beat_data", s_rdata, exp_data[idx]);
                        check("beat_ctl", 64'({s_rresp, s_rlast, s_rid}), 64'(exp_ctl[idx]));
                        if (mode == 0) check("beat_cycle", 64'(c), 64'(idx + 2));
                    end
                    if (s_rlast) done = 1;
                    idx++;
                end
            end
            held_v    = s_rvalid && !s_rready;
            held_data = s_rdata;
            held_ctl  = {s_rvalid, s_rresp, s_rlast, s_rid};
            @(posedge clk); #1;
            c++;
        end
        check("beat_count", 64'(idx), 64'(int'(len) + 1));
        check("mem_en_count", 64'(en_total - en_base), 64'(exp_ok));
        check("arready_after_last", 64'(s_arready), 64'd1);
        check("rvalid_after_last", 64'(s_rvalid), 64'd0);
        s_rready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        check("reset_arready", 64'(s_arready), 64'd0);
        check("reset_rvalid", 64'(s_rvalid), 64'd0);
        check("reset_mem_en", 64'(mem_en), 64'd0);
        check("reset_rdata", s_rdata, 64'd0);
        check("reset_ctl", 64'({s_rresp, s_rlast, s_rid}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("arready_first_edge", 64'(s_arready), 64'd1);

        run_burst(BASE + 32'h10, 4'd5, 8'd3, 3'd3, 2'b01, 0, -1);
        run_burst(BASE + 32'h28, 4'd2, 8'd3, 3'd3, 2'b10, 0, -1);
        run_burst(BASE + 32'h10, 4'd5, 8'd3, 3'd3, 2'b01, 1, -1);
        run_burst(BASE + 32'(DEPTH * 8), 4'd7, 8'd1, 3'd3, 2'b01, 0, -1);
        run_burst(BASE + 32'h40, 4'd9, 8'd0, 3'd4, 2'b01, 0, -1);
        run_burst(BASE + 32'h40, 4'd1, 8'd2, 3'd3, 2'b11, 1, -1);
        run_burst(BASE + 32'h40, 4'd3, 8'd2, 3'd3, 2'b10, 0, -1);
        run_burst(BASE + 32'h18, 4'd4, 8'd4, 3'd2, 2'b00, 1, -1);
        run_burst(BASE + 32'(DEPTH * 8) - 32'd16, 4'd6, 8'd3, 3'd3, 2'b01, 0, -1);
        run_burst(BASE - 32'd8, 4'd8, 8'd1, 3'd3, 2'b01, 0, -1);
        run_burst(BASE + 32'h60, 4'd10, 8'd7, 3'd1, 2'b10, 1, -1);
        run_burst(BASE + 32'h80, 4'd11, 8'd7, 3'd3, 2'b01, 0, 1);
        run_burst(BASE + 32'h20, 4'd12, 8'd2, 3'd3, 2'b01, 0, -1);

        for (int k = 0; k < 14; k++) begin
            logic [2:0]  sz;
            logic [1:0]  bu;
            logic [7:0]  ln;
            logic [31:0] ad;
            sz = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            bu = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (bu == 2'b10) begin
                case ($urandom_range(0, 4))
                    0: ln = 8'd1;
                    1: ln = 8'd3;
                    2: ln = 8'd7;
                    3: ln = 8'd15;
                    default: ln = 8'd5;
                endcase
            end else begin
                ln = 8'($urandom_range(0, 15));
            end
            ad = BASE + 32'($urandom_range(0, DEPTH * 8 + 127)) - 32'd64;
            ad = ad & ~((32'd1 << sz) - 32'd1);
            run_burst(ad, 4'($urandom_range(0, 15)), ln, sz, bu, 2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4r_sram_slave.md
AXI4R_SRAM_SLAVE -- requirements
Module: axi4r_sram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 64-bit memory words (power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports s_arready/s_arvalid/s_araddr[31:0]/s_arid[3:0]/s_arlen[7:0]/s_arsize[2:0]/s_arburst[1:0]/s_rready/s_rvalid/s_rresp[1:0]/s_rdata[63:0]/s_rlast/s_rid[3:0] with AXI4 read-slave directions (AR request, rready inputs; arready, R outputs).
REQ-006 SHALL have port mem_en  output  1  synchronous SRAM read strobe.
REQ-007 SHALL have port mem_addr  output  $clog2(DEPTH)  SRAM word index.
REQ-008 SHALL have port mem_rdata  input  64  SRAM data, valid exactly one cycle after mem_en.

Function
REQ-009 SHALL use FSM states IDLE and BURST; one outstanding AR at a time.
REQ-010 SHALL drive s_arready=1 only in IDLE; AR handshake (arvalid&arready) latches addr, id, len, size, burst and moves to BURST.
REQ-011 SHALL return to IDLE the cycle after the beat with s_rlast=1 is accepted (rvalid&rready); arready=1 that same cycle.
REQ-012 SHALL produce exactly arlen+1 R beats; s_rlast=1 on final beat only; s_rid=latched arid on every beat.
REQ-013 SHALL compute beat address: FIXED(2'b00) constant; INCR(2'b01) += 1<<arsize; WRAP(2'b10) increments and wraps to aligned boundary of (arlen+1)<<arsize bytes.
REQ-014 SHALL map word index = (addr-BASE_ADDR)>>3, truncated to $clog2(DEPTH) bits.
REQ-015 SHALL use 2-entry output FIFO; issue mem_en only when FIFO occupancy plus in-flight reads < 2 and beats remain.
REQ-016 SHALL deliver first beat's s_rvalid 2 cycles after AR handshake (handshake T, mem_en T+1, rvalid T+2) with rready held 1.
REQ-017 SHALL sustain one beat per cycle while rready=1 after the first beat.
REQ-018 SHALL hold s_rdata/s_rresp/s_rlast/s_rid stable while s_rvalid=1 and s_rready=0.
REQ-019 SHALL respond rresp=2'b11 (DECERR), rdata=0, no mem_en, for beats with address outside [BASE_ADDR, BASE_ADDR+DEPTH*8).
REQ-020 SHALL respond rresp=2'b10 (SLVERR), rdata=0, no mem_en, for all beats when arsize>3, arburst=2'b11, or WRAP with arlen not in {1,3,7,15}; still arlen+1 beats.
REQ-021 SHALL respond rresp=2'b00 for valid in-range beats; rdata=mem_rdata for aligned 64-bit word (narrow sizes return full word, no lane shifting).
REQ-022 SHALL ignore s_arvalid while in BURST; request stays pending until arready.

Reset
REQ-023 SHALL, on rst_n=0, immediately force state IDLE, FIFO empty, in-flight cleared, s_rvalid=0, s_rlast=0, s_rid=0, s_rresp=0, s_rdata=0, mem_en=0, s_arready=0.
REQ-024 SHALL drive s_arready=1 from the first clock edge after rst_n deasserts.
REQ-025 SHALL, on reset mid-burst, discard all remaining beats and in-flight SRAM data.

Verification
REQ-026 INCR arlen=3, arsize=3, araddr=BASE+0x10, arid=5, rready=1 -> 4 beats words 2,3,4,5, rvalid at T+2..T+5, rlast on 4th, rid=5, rresp=0.
REQ-027 WRAP arlen=3, arsize=3, araddr=BASE+0x28 -> words 5,6,7,4; rlast on word 4.
REQ-028 Same INCR with rready toggling 1,0,0,1,... -> data unchanged while stalled, no beat lost/duplicated, at most 2 reads outstanding.
REQ-029 araddr=BASE+DEPTH*8, arlen=1 -> 2 beats rresp=2'b11, rdata=0, mem_en never asserted.
REQ-030 arsize=4, arlen=0 -> 1 beat rresp=2'b10, rlast=1; then arready=1 next cycle.
REQ-031 rst_n=0 during beat 2 of 8 -> rvalid=0 immediately, arready=1 after release, next AR served normally.
